// File: rtl/rtc_pkg.sv
// Shared types and helpers for the lap stopwatch: FSM states, seven-segment
// encoding and per-digit modulus.
package rtc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is left off here
  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Tens-of-seconds and tens-of-minutes digits roll at 6
  function automatic logic [3:0] digit_mod(input int i);
    return (i == 3 || i == 5) ? 4'd6 : 4'd10;
  endfunction

endpackage

// File: rtl/rtc_lap_fifo.sv
// Small synchronous lap FIFO; head is valid combinationally, push+pop when
// full is accepted so occupancy stays put.
module rtc_lap_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, do_push, do_pop;

  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && (!full_q || do_pop);
  assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_q] <= wdata;
  end

  assign head  = mem[rd_q];
  assign empty = (cnt_q == '0);
  assign full  = full_q;
  assign count = cnt_q;

endmodule

// File: rtl/rtc_lap_stopwatch.sv
// Stopwatch core: start/stop FSM, prescaler, BCD count, lap FIFO with recall
// and multiplexed 7-seg scan. RTC_LEADING_ZERO_BLANK_EN blanks leading zeros.
module rtc_lap_stopwatch
  import rtc_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 100,
  parameter int NUM_DIGITS = 6,
  parameter int LAP_DEPTH  = 4,
  parameter int SCAN_DIV   = 100_000
) (
  input  logic                             i_sys_clk,
  input  logic                             i_reset,
  input  logic                             i_start_stop,
  input  logic                             i_lap_clear,
  input  logic                             i_lap_read,
  output logic                             o_running,
  output logic                             o_showing_lap,
  output logic [$clog2(LAP_DEPTH+1)-1:0]   o_lap_count,
  output logic                             o_lap_full,
  output logic                             o_overflow,
  output logic [NUM_DIGITS-1:0]            o_digits,
  output logic [7:0]                       o_segments
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int SW  = $clog2(SCAN_DIV);
  localparam int IW  = $clog2(NUM_DIGITS);
  localparam int BW  = 4 * NUM_DIGITS;

  state_e                state_q, state_d;
  logic                  do_push, do_clear, tick, wrap;
  logic                  running_q, showing_q, overflow_q, fifo_empty;
  logic [PW-1:0]         pre_q;
  logic [BW-1:0]         cnt_q, cnt_d, hold_q, src, head;
  logic [SW-1:0]         scan_q;
  logic [IW-1:0]         idx_q;
  int unsigned           idx_n;
  logic [3:0]            cur;
  logic [7:0]            seg_d, seg_q;
  logic [NUM_DIGITS-1:0] digits_q;

  // start_stop takes priority: lap_clear only acts when start_stop is absent
  always_comb begin
    state_d  = state_q;
    do_push  = 1'b0;
    do_clear = 1'b0;
    case (state_q)
      S_IDLE: if (i_start_stop) state_d = S_RUN;
      S_RUN: begin
        if (i_start_stop)     state_d = S_STOP;
        else if (i_lap_clear) do_push = 1'b1;
      end
      S_STOP: begin
        if (i_start_stop) state_d = S_RUN;
        else if (i_lap_clear) begin
          state_d  = S_IDLE;
          do_clear = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tick = (pre_q == PW'(DIV-1)) && (state_q == S_RUN);

  always_comb begin : bcd_inc
    logic carry;
    cnt_d = cnt_q;
    carry = tick;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] == digit_mod(i) - 4'd1) begin
          cnt_d[4*i +: 4] = 4'd0;
        end else begin
          cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  rtc_lap_fifo #(.WIDTH(BW), .DEPTH(LAP_DEPTH)) u_fifo (
    .clk   (i_sys_clk),
    .rst   (i_reset),
    .clr   (do_clear),
    .push  (do_push),
    .wdata (cnt_q),
    .pop   (i_lap_read),
    .head  (head),
    .empty (fifo_empty),
    .full  (o_lap_full),
    .count (o_lap_count)
  );

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      running_q  <= 1'b0;
      pre_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      showing_q  <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == S_RUN);
      if (do_clear) begin
        pre_q      <= '0;
        cnt_q      <= '0;
        overflow_q <= 1'b0;
      end else if (state_q == S_RUN) begin
        pre_q <= tick ? '0 : pre_q + 1'b1;
        cnt_q <= cnt_d;
        if (wrap) overflow_q <= 1'b1;
      end
      if (do_clear)        showing_q <= 1'b0;
      else if (i_lap_read) showing_q <= !fifo_empty;
      if (i_lap_read && !fifo_empty) hold_q <= head;
    end
  end

  assign idx_n = {{(32-IW){1'b0}}, idx_q};

  always_comb begin
    src   = showing_q ? hold_q : cnt_q;
    cur   = src[4*idx_n +: 4];
    seg_d = seg_encode(cur);
    if (idx_n == 2 || idx_n == 4) seg_d[7] = 1'b0;
`ifdef RTC_LEADING_ZERO_BLANK_EN
    if (idx_n >= 3 && (src >> (4*idx_n)) == '0) seg_d = SEG_BLANK;
`endif
  end

  // Digit enable and segments both come from idx_q, so they switch together
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      scan_q   <= '0;
      idx_q    <= '0;
      digits_q <= ~NUM_DIGITS'(1);
      seg_q    <= 8'hC0;
    end else begin
      if (scan_q == SW'(SCAN_DIV-1)) begin
        scan_q <= '0;
        idx_q  <= (idx_q == IW'(NUM_DIGITS-1)) ? '0 : idx_q + 1'b1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
      digits_q <= ~(NUM_DIGITS'(1) << idx_q);
      seg_q    <= seg_d;
    end
  end

  assign o_running     = running_q;
  assign o_showing_lap = showing_q;
  assign o_overflow    = overflow_q;
  assign o_digits      = digits_q;
  assign o_segments    = seg_q;

endmodule
